sp_render: RTL and testbench

- Sprite pixel generator: the consumer side of secondary OAM.
- Loads up to 8 pre-fetched sprite entries (position, attributes, bitmap planes) from secondary OAM once per scanline, in the TL_PRE_CYC window.
- During the next visible scanline, counts down X positions and shifts bitmaps to produce one sprite pixel per PPU cycle.
- Feeds the pixel mux with colour, priority and sprite-0 flags.

---
 rtl/sp_render_pkg.sv | 37 +++
 rtl/sp_render_if.sv | 30 +++
 rtl/sp_render_slot.sv | 65 ++++++
 rtl/sp_render.sv | 113 +++++++++++
 tb/tb_sp_render.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sp_render_pkg.sv
// Shared types and constants for the sprite pixel generator.
// Covers the horizontal-state and secondary OAM types, plus the sprite attribute bit positions.
package sp_render_pkg;

    localparam int unsigned SP_SLOTS          = 8;
    localparam int unsigned SP_LOAD_START_COL = 321;
    localparam int unsigned COL_W             = 9;
    localparam int unsigned X_W               = 8;
    localparam int unsigned IDX_W             = 3;

    localparam int unsigned SPR_ATTR_FLIP_V   = 7;
    localparam int unsigned SPR_ATTR_FLIP_H   = 6;
    localparam int unsigned SPR_ATTR_PRIO     = 5;
    localparam int unsigned SPR_ATTR_PAL_LO   = 0;

    typedef enum logic [1:0] {
        SL_PRE_CYC  = 2'd0,
        SL_POST_CYC = 2'd1,
        TL_PRE_CYC  = 2'd2,
        TL_POST_CYC = 2'd3
    } hs_state_t;

    typedef struct packed {
        logic           active;
        logic [X_W-1:0] x_pos;
        logic [7:0]     attribute;
        logic [7:0]     bitmap_lo;
        logic [7:0]     bitmap_hi;
    } second_oam_t;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

endpackage

// File: rtl/sp_render_if.sv
// Bundles the sprite renderer's timing inputs, its secondary OAM read port and its pixel outputs.
// The slave modport is the renderer's view; the master modport is the surrounding PPU's view.
interface sp_render_if;

    logic                       clk_en;
    logic [8:0]                 row;
    logic [8:0]                 col;
    sp_render_pkg::hs_state_t   hs_state;
    logic                       show_sprites;
    logic                       show_left8;
    logic                       sprite0_present;
    logic [2:0]                 sec_oam_rd_idx;
    sp_render_pkg::second_oam_t sec_oam_rd_data;
    logic [3:0]                 sp_pixel;
    logic                       sp_behind_bg;
    logic                       sp_is_zero;

    modport slave (
        input  clk_en, row, col, hs_state, show_sprites, show_left8,
        input  sprite0_present, sec_oam_rd_data,
        output sec_oam_rd_idx, sp_pixel, sp_behind_bg, sp_is_zero
    );

    modport master (
        output clk_en, row, col, hs_state, show_sprites, show_left8,
        output sprite0_present, sec_oam_rd_data,
        input  sec_oam_rd_idx, sp_pixel, sp_behind_bg, sp_is_zero
    );

endinterface

// File: rtl/sp_render_slot.sv
// One sprite channel: the X down-counter, the bitmap shift registers and the attribute bits.
// The pattern and live flags are combinational views of the current state.
module sp_slot
    import sp_render_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic        i_render,
    input  second_oam_t i_entry,
    output logic        o_live_c,
    output logic [1:0]  o_pattern_c,
    output logic [1:0]  o_palette,
    output logic        o_behind
);

    logic           r_active;
    logic [X_W-1:0] r_x_cnt;
    logic [7:0]     r_lo;
    logic [7:0]     r_hi;
    logic [1:0]     r_palette;
    logic           r_behind;

    // Vertical flip is already resolved in the fetched bitmap.
    wire w_unused_attr = &{1'b0, i_entry.attribute[SPR_ATTR_FLIP_V], i_entry.attribute[4:2]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_x_cnt   <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_palette <= '0;
            r_behind  <= 1'b0;
        end else if (i_en && i_load) begin
            r_active  <= i_entry.active;
            r_palette <= i_entry.attribute[SPR_ATTR_PAL_LO +: 2];
            r_behind  <= i_entry.attribute[SPR_ATTR_PRIO];
            if (i_entry.active) begin
                r_x_cnt <= i_entry.x_pos;
                r_lo    <= i_entry.attribute[SPR_ATTR_FLIP_H] ? rev8(i_entry.bitmap_lo) : i_entry.bitmap_lo;
                r_hi    <= i_entry.attribute[SPR_ATTR_FLIP_H] ? rev8(i_entry.bitmap_hi) : i_entry.bitmap_hi;
            end else begin
                r_x_cnt <= '0;
                r_lo    <= '0;
                r_hi    <= '0;
            end
        end else if (i_en && i_render) begin
            // Count down to the sprite's column, then shift one pixel per cycle.
            if (r_x_cnt != '0) begin
                r_x_cnt <= r_x_cnt - X_W'(1);
            end else begin
                r_lo <= {r_lo[6:0], 1'b0};
                r_hi <= {r_hi[6:0], 1'b0};
            end
        end
    end

    assign o_live_c    = r_active && (r_x_cnt == '0);
    assign o_pattern_c = {r_hi[7], r_lo[7]};
    assign o_palette   = r_palette;
    assign o_behind    = r_behind;

endmodule

// File: rtl/sp_render.sv
// Sprite pixel generator: loads the slots from secondary OAM during the load window,
// then picks the highest-priority opaque sprite pixel each visible cycle.
module sp_render
    import sp_render_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = SP_SLOTS,
    parameter int unsigned LOAD_START_COL = SP_LOAD_START_COL
) (
    input  logic        clk,
    input  logic        rst_n,
    sp_render_if.slave  bus
);

    logic [IDX_W-1:0]     w_rd_idx;
    logic                 w_in_window;
    logic                 w_load;
    logic                 w_render;
    logic [NUM_SLOTS-1:0] w_load_vec;
    logic [NUM_SLOTS-1:0] w_live;
    logic [NUM_SLOTS-1:0] w_behind;
    logic [1:0]           w_pat [NUM_SLOTS];
    logic [1:0]           w_pal [NUM_SLOTS];

    logic                 w_mask;
    logic [3:0]           w_win_pixel;
    logic                 w_win_behind;
    logic                 w_win_zero;

    logic                 r_sprite0;
    logic [3:0]           r_pixel;
    logic                 r_behind_bg;
    logic                 r_is_zero;

    // The scanline number is not needed to render the pixels.
    wire w_unused_row = &{1'b0, bus.row};

    assign w_rd_idx           = IDX_W'(bus.col - COL_W'(LOAD_START_COL));
    assign bus.sec_oam_rd_idx = w_rd_idx;

    assign w_in_window = (bus.col >= COL_W'(LOAD_START_COL)) &&
                         (bus.col <  COL_W'(LOAD_START_COL + NUM_SLOTS));
    assign w_load      = bus.clk_en && (bus.hs_state == TL_PRE_CYC) && w_in_window;
    assign w_render    = (bus.hs_state == SL_PRE_CYC);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign w_load_vec[g] = w_load && (w_rd_idx == IDX_W'(g));

        sp_slot u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_en        (bus.clk_en),
            .i_load      (w_load_vec[g]),
            .i_render    (w_render),
            .i_entry     (bus.sec_oam_rd_data),
            .o_live_c    (w_live[g]),
            .o_pattern_c (w_pat[g]),
            .o_palette   (w_pal[g]),
            .o_behind    (w_behind[g])
        );
    end

    // Lowest-index opaque slot wins; the scan runs high to low so the last hit is the winner.
    always_comb begin
        w_win_pixel  = '0;
        w_win_behind = 1'b0;
        w_win_zero   = 1'b0;
        w_mask       = !bus.show_sprites || ((bus.col < COL_W'(8)) && !bus.show_left8);
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_live[i] && (w_pat[i] != 2'b00)) begin
                w_win_pixel  = {w_pal[i], w_pat[i]};
                w_win_behind = w_behind[i];
                w_win_zero   = (i == 0) && r_sprite0;
            end
        end
        if (w_mask) begin
            w_win_pixel  = '0;
            w_win_behind = 1'b0;
            w_win_zero   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sprite0 <= 1'b0;
        end else if (w_load_vec[0]) begin
            r_sprite0 <= bus.sprite0_present;
        end
    end

    // One PPU cycle of latency: the pixel for column c is presented during cycle c+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pixel     <= '0;
            r_behind_bg <= 1'b0;
            r_is_zero   <= 1'b0;
        end else if (bus.clk_en) begin
            if (w_render) begin
                r_pixel     <= w_win_pixel;
                r_behind_bg <= w_win_behind;
                r_is_zero   <= w_win_zero;
            end else begin
                r_pixel     <= '0;
                r_behind_bg <= 1'b0;
                r_is_zero   <= 1'b0;
            end
        end
    end

    assign bus.sp_pixel     = r_pixel;
    assign bus.sp_behind_bg = r_behind_bg;
    assign bus.sp_is_zero   = r_is_zero;

endmodule

// File: tb/tb_sp_render.sv
// Directed and randomized scanlines for sp_render, checked against a per-column model
// that computes which sprite covers each column directly from the loaded entries.
module tb_sp_render;
    import sp_render_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sp_render_if bus ();

    sp_render #(.NUM_SLOTS(SP_SLOTS), .LOAD_START_COL(SP_LOAD_START_COL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    second_oam_t sec_oam [SP_SLOTS];
    second_oam_t mdl     [SP_SLOTS];
    logic        mdl_s0;
    logic        mdl_ok;

    always_comb bus.sec_oam_rd_data = sec_oam[bus.sec_oam_rd_idx];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input int c, input logic [5:0] obs, input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s col=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {bus.sp_pixel, bus.sp_behind_bg, bus.sp_is_zero};
    endfunction

    // Expected {pixel, behind, is_zero} for column c, from the entries captured at load time.
    function automatic logic [5:0] model_px(input int c);
        int       x;
        int       k;
        logic [2:0] b;
        logic [1:0] pat;
        if (!mdl_ok || !bus.show_sprites || (c < 8 && !bus.show_left8)) return 6'd0;
        for (int i = 0; i < SP_SLOTS; i++) begin
            x = int'(mdl[i].x_pos);
            if (mdl[i].active && c >= x && c < x + 8) begin
                k   = c - x;
                b   = mdl[i].attribute[6] ? 3'(k) : 3'(7 - k);
                pat = {mdl[i].bitmap_hi[b], mdl[i].bitmap_lo[b]};
                if (pat != 2'b00)
                    return {mdl[i].attribute[1:0], pat, mdl[i].attribute[5], (i == 0) && mdl_s0};
            end
        end
        return 6'd0;
    endfunction

    function automatic second_oam_t rnd_entry();
        second_oam_t e;
        e.active    = 1'($urandom_range(0, 1));
        e.x_pos     = 8'($urandom_range(0, 255));
        e.attribute = 8'($urandom);
        e.bitmap_lo = 8'($urandom);
        e.bitmap_hi = 8'($urandom);
        return e;
    endfunction

    // One PPU cycle: clk_en high for one master clock, then low for three.
    task automatic tick(input hs_state_t hs, input int c);
        bus.hs_state = hs;
        bus.col      = 9'(c);
        bus.clk_en   = 1'b1;
        @(posedge clk);
        #1 bus.clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_oam();
        for (int i = 0; i < SP_SLOTS; i++) sec_oam[i] = '0;
    endtask

    task automatic load_line();
        tick(TL_POST_CYC, 320);
        for (int c = 321; c < 329; c++) begin
            tick(TL_PRE_CYC, c);
            check("rd_idx", c, {3'b000, bus.sec_oam_rd_idx}, 6'(c - 321));
        end
        for (int i = 0; i < SP_SLOTS; i++) mdl[i] = sec_oam[i];
        mdl_s0 = bus.sprite0_present;
        mdl_ok = 1'b1;
        // Fresh OAM contents after the window must not leak into the loaded slots.
        for (int i = 0; i < SP_SLOTS; i++) sec_oam[i] = '{1'b1, 8'($urandom), 8'($urandom), 8'hFF, 8'hFF};
        tick(TL_PRE_CYC, 329);
        tick(TL_PRE_CYC, 330);
        tick(TL_POST_CYC, 340);
    endtask

    task automatic render_line(input int rst_col);
        for (int c = 0; c < 256; c++) begin
            if (c == rst_col) begin
                rst_n  = 1'b0;
                mdl_ok = 1'b0;
            end
            tick(SL_PRE_CYC, c);
            rst_n = 1'b1;
            check(c == rst_col ? "reset_mid" : "pixel", c, dut_out(), model_px(c));
        end
        tick(SL_POST_CYC, 256);
        check("post_line", 256, dut_out(), 6'd0);
    endtask

    task automatic do_line(input int rst_col);
        load_line();
        render_line(rst_col);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.clk_en          = 1'b0;
        bus.row             = 9'd0;
        bus.col             = 9'd0;
        bus.hs_state        = SL_POST_CYC;
        bus.show_sprites    = 1'b1;
        bus.show_left8      = 1'b1;
        bus.sprite0_present = 1'b0;
        mdl_ok              = 1'b0;
        mdl_s0              = 1'b0;
        clear_oam();
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, dut_out(), 6'd0);
        rst_n = 1'b1;

        // Plain sprite at x=10, then the same sprite horizontally flipped.
        bus.row = 9'd1;
        clear_oam();
        sec_oam[0] = '{1'b1, 8'd10, 8'h01, 8'hF0, 8'h0F};
        do_line(-1);
        clear_oam();
        sec_oam[0] = '{1'b1, 8'd10, 8'h41, 8'hF0, 8'h0F};
        do_line(-1);

        // Overlapping slots 2 and 5; slot 2 is transparent at its second pixel.
        clear_oam();
        sec_oam[2] = '{1'b1, 8'd20, 8'h22, 8'hBF, 8'h00};
        sec_oam[5] = '{1'b1, 8'd20, 8'h03, 8'hFF, 8'h00};
        do_line(-1);

        // Sprite 0 straddling the left-8 mask.
        clear_oam();
        bus.show_left8      = 1'b0;
        bus.sprite0_present = 1'b1;
        sec_oam[0] = '{1'b1, 8'd4, 8'h00, 8'hFF, 8'h00};
        do_line(-1);
        bus.show_left8      = 1'b1;
        bus.sprite0_present = 1'b0;

        // All slots inactive with junk bitmaps, then a valid line, then sprites disabled.
        for (int i = 0; i < SP_SLOTS; i++) begin
            sec_oam[i]        = rnd_entry();
            sec_oam[i].active = 1'b0;
        end
        do_line(-1);
        for (int i = 0; i < SP_SLOTS; i++) sec_oam[i] = rnd_entry();
        do_line(-1);
        bus.show_sprites = 1'b0;
        for (int i = 0; i < SP_SLOTS; i++) sec_oam[i] = rnd_entry();
        do_line(-1);
        bus.show_sprites = 1'b1;

        // Reset at column 100 with a sprite due at 120; rendering resumes after the next load.
        clear_oam();
        sec_oam[0] = '{1'b1, 8'd120, 8'h01, 8'hFF, 8'hAA};
        do_line(100);
        clear_oam();
        sec_oam[0] = '{1'b1, 8'd120, 8'h01, 8'hFF, 8'hAA};
        do_line(-1);

        // Randomized lines, including sprites clipped at the right edge.
        for (int n = 0; n < 8; n++) begin
            bus.row             = 9'(n + 10);
            bus.show_left8      = 1'($urandom_range(0, 1));
            bus.sprite0_present = 1'($urandom_range(0, 1));
            for (int i = 0; i < SP_SLOTS; i++) sec_oam[i] = rnd_entry();
            if (n == 0) sec_oam[7].x_pos = 8'd252;
            do_line(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
